ascon_perm_round_ctrl: RTL and testbench

- Sequencer for the two-rounds-per-cycle Ascon permutation datapath: odd and even constant-addition stages, S-box and linear layer.
- Accepts one permutation request (pa or pb, Ascon-128 or -128a), then drives loop_num, state load/enable strobes and the constant-select controls until the last double-round.
- Raises done for one cycle, then returns to idle.
- Sits between the mode/absorb FSM and the permutation state register.

---
 rtl/ascon_pkg.sv | 56 +++++
 rtl/ascon_loop_counter.sv | 38 +++
 rtl/ascon_perm_round_ctrl.sv | 150 +++++++++++++++
 tb/tb_ascon_perm_round_ctrl.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/ascon_pkg.sv
// Shared definitions for the Ascon permutation sequencer and its
// constant-addition stages: FSM states, permutation encodings, loop
// bounds and the round-constant table.
package ascon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } perm_state_e;

  localparam logic PERM_PA = 1'b0;
  localparam logic PERM_PB = 1'b1;

  localparam logic [2:0] PA_START     = 3'd0;  // 12 rounds = 6 double-rounds
  localparam logic [2:0] PB128_START  = 3'd3;  // 6 rounds  = 3 double-rounds
  localparam logic [2:0] PB128A_START = 3'd2;  // 8 rounds  = 4 double-rounds
  localparam logic [2:0] LAST_LOOP    = 3'd5;

  // First double-round index for a given permutation/variant pair.
  // The variant only matters for pb; pa always runs the full 12 rounds.
  function automatic logic [2:0] start_loop(input logic perm_sel, input logic variant);
    logic [2:0] val;
    if (perm_sel == PERM_PA) begin
      val = PA_START;
    end else if (variant == 1'b1) begin
      val = PB128A_START;
    end else begin
      val = PB128_START;
    end
    return val;
  endfunction

  // Ascon round constants, indexed by absolute round 0..11. A double-round
  // at loop_num n uses entries 2n (odd stage) and 2n+1 (even stage).
  function automatic logic [7:0] round_const(input logic [3:0] idx);
    logic [7:0] rc;
    case (idx)
      4'd0:    rc = 8'hf0;
      4'd1:    rc = 8'he1;
      4'd2:    rc = 8'hd2;
      4'd3:    rc = 8'hc3;
      4'd4:    rc = 8'hb4;
      4'd5:    rc = 8'ha5;
      4'd6:    rc = 8'h96;
      4'd7:    rc = 8'h87;
      4'd8:    rc = 8'h78;
      4'd9:    rc = 8'h69;
      4'd10:   rc = 8'h5a;
      4'd11:   rc = 8'h4b;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/ascon_loop_counter.sv
// Loadable 3-bit double-round counter. Loads the start index for the
// requested permutation, increments up to LAST_LOOP and holds there.
module ascon_loop_counter
  import ascon_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic       inc_i,
  input  logic       clr_i,
  input  logic       perm_sel_i,
  input  logic       variant_i,
  output logic [2:0] count_o,
  output logic       last_o
);

  logic [2:0] count_r;

  // Counter register: clear has priority over load, load over increment;
  // the increment saturates at LAST_LOOP so 6 and 7 are never reached.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= 3'd0;
    end else if (clr_i) begin
      count_r <= 3'd0;
    end else if (load_i) begin
      count_r <= start_loop(perm_sel_i, variant_i);
    end else if (inc_i && (count_r != LAST_LOOP)) begin
      count_r <= count_r + 3'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign count_o = count_r;
  assign last_o  = (count_r == LAST_LOOP);

endmodule

// File: rtl/ascon_perm_round_ctrl.sv
// Round sequencer for the two-rounds-per-cycle Ascon permutation. Accepts
// one pa/pb request, steps loop_num through the double-rounds while driving
// the state register strobes, then pulses done for one cycle.
module ascon_perm_round_ctrl
  import ascon_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       perm_sel_i,
  input  logic       variant_i,
  input  logic       mode_i,
  output logic       ready_o,
  output logic       busy_o,
  output logic [2:0] loop_num_o,
  output logic       const_sel_o,
  output logic       compact_fast_o,
  output logic       state_load_o,
  output logic       state_en_o,
  output logic       done_o
);

  perm_state_e state_r, state_nxt_s;

  logic perm_r, variant_r, mode_r;
  logic perm_nxt_s, variant_nxt_s, mode_nxt_s;

  logic ready_r, busy_r, const_sel_r, compact_fast_r;
  logic state_load_r, state_en_r, done_r;
  logic ready_nxt_s, busy_nxt_s, const_sel_nxt_s, compact_fast_nxt_s;
  logic state_load_nxt_s, state_en_nxt_s, done_nxt_s;

  logic cnt_load_s, cnt_inc_s, cnt_clr_s, cnt_last_s;
  logic [2:0] cnt_val_s;

  ascon_loop_counter u_loop_counter (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load_s),
    .inc_i      (cnt_inc_s),
    .clr_i      (cnt_clr_s),
    .perm_sel_i (perm_sel_i),
    .variant_i  (variant_i),
    .count_o    (cnt_val_s),
    .last_o     (cnt_last_s)
  );

  // Next-state, latched config and next values of the registered outputs.
  always_comb begin
    state_nxt_s        = state_r;
    perm_nxt_s         = perm_r;
    variant_nxt_s      = variant_r;
    mode_nxt_s         = mode_r;
    ready_nxt_s        = 1'b0;
    busy_nxt_s         = 1'b0;
    const_sel_nxt_s    = 1'b0;
    compact_fast_nxt_s = 1'b0;
    state_load_nxt_s   = 1'b0;
    state_en_nxt_s     = 1'b0;
    done_nxt_s         = 1'b0;
    cnt_load_s         = 1'b0;
    cnt_inc_s          = 1'b0;
    cnt_clr_s          = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_i) begin
          state_nxt_s        = ROUND;
          perm_nxt_s         = perm_sel_i;
          variant_nxt_s      = variant_i;
          mode_nxt_s         = mode_i;
          busy_nxt_s         = 1'b1;
          const_sel_nxt_s    = (perm_sel_i == PERM_PB) && variant_i;
          compact_fast_nxt_s = mode_i;
          state_load_nxt_s   = 1'b1;
          state_en_nxt_s     = 1'b1;
          cnt_load_s         = 1'b1;
        end else begin
          ready_nxt_s = 1'b1;
        end
      end
      ROUND: begin
        busy_nxt_s         = 1'b1;
        const_sel_nxt_s    = (perm_r == PERM_PB) && variant_r;
        compact_fast_nxt_s = mode_r;
        if (cnt_last_s) begin
          state_nxt_s = DONE;
          done_nxt_s  = 1'b1;
        end else begin
          state_en_nxt_s = 1'b1;
          cnt_inc_s      = 1'b1;
        end
      end
      DONE: begin
        state_nxt_s   = IDLE;
        perm_nxt_s    = 1'b0;
        variant_nxt_s = 1'b0;
        mode_nxt_s    = 1'b0;
        ready_nxt_s   = 1'b1;
        cnt_clr_s     = 1'b1;
      end
      default: begin
        state_nxt_s   = IDLE;
        perm_nxt_s    = 1'b0;
        variant_nxt_s = 1'b0;
        mode_nxt_s    = 1'b0;
        ready_nxt_s   = 1'b1;
        cnt_clr_s     = 1'b1;
      end
    endcase
  end

  // State, latched config and output registers; reset abandons any permutation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= IDLE;
      perm_r         <= 1'b0;
      variant_r      <= 1'b0;
      mode_r         <= 1'b0;
      ready_r        <= 1'b1;
      busy_r         <= 1'b0;
      const_sel_r    <= 1'b0;
      compact_fast_r <= 1'b0;
      state_load_r   <= 1'b0;
      state_en_r     <= 1'b0;
      done_r         <= 1'b0;
    end else begin
      state_r        <= state_nxt_s;
      perm_r         <= perm_nxt_s;
      variant_r      <= variant_nxt_s;
      mode_r         <= mode_nxt_s;
      ready_r        <= ready_nxt_s;
      busy_r         <= busy_nxt_s;
      const_sel_r    <= const_sel_nxt_s;
      compact_fast_r <= compact_fast_nxt_s;
      state_load_r   <= state_load_nxt_s;
      state_en_r     <= state_en_nxt_s;
      done_r         <= done_nxt_s;
    end
  end

  assign ready_o        = ready_r;
  assign busy_o         = busy_r;
  assign loop_num_o     = cnt_val_s;
  assign const_sel_o    = const_sel_r;
  assign compact_fast_o = compact_fast_r;
  assign state_load_o   = state_load_r;
  assign state_en_o     = state_en_r;
  assign done_o         = done_r;

endmodule

// File: tb/tb_ascon_perm_round_ctrl.sv
// Directed testbench for the Ascon permutation round sequencer.
module tb_ascon_perm_round_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_i;
  logic       perm_sel_i;
  logic       variant_i;
  logic       mode_i;
  logic       ready_o;
  logic       busy_o;
  logic [2:0] loop_num_o;
  logic       const_sel_o;
  logic       compact_fast_o;
  logic       state_load_o;
  logic       state_en_o;
  logic       done_o;

  int n_checks = 0;
  int n_errors = 0;

  ascon_perm_round_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start_i),
    .perm_sel_i     (perm_sel_i),
    .variant_i      (variant_i),
    .mode_i         (mode_i),
    .ready_o        (ready_o),
    .busy_o         (busy_o),
    .loop_num_o     (loop_num_o),
    .const_sel_o    (const_sel_o),
    .compact_fast_o (compact_fast_o),
    .state_load_o   (state_load_o),
    .state_en_o     (state_en_o),
    .done_o         (done_o)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Idle/reset output pattern.
  task automatic check_idle(input string tag);
    check_val({tag, ".ready"},  {31'd0, ready_o},        32'd1);
    check_val({tag, ".busy"},   {31'd0, busy_o},         32'd0);
    check_val({tag, ".loop"},   {29'd0, loop_num_o},     32'd0);
    check_val({tag, ".csel"},   {31'd0, const_sel_o},    32'd0);
    check_val({tag, ".cf"},     {31'd0, compact_fast_o}, 32'd0);
    check_val({tag, ".load"},   {31'd0, state_load_o},   32'd0);
    check_val({tag, ".en"},     {31'd0, state_en_o},     32'd0);
    check_val({tag, ".done"},   {31'd0, done_o},         32'd0);
  endtask

  // One permutation from accept to the first IDLE cycle. exp_start,
  // exp_rounds, exp_cs, exp_cf are hand-computed expectations. inj_round
  // pulses start_i (with other config) during that ROUND cycle; done_start
  // pulses start_i on the done_o cycle.
  task automatic run_perm(input string tag, input logic ps, input logic vr, input logic md,
                          input int exp_start, input int exp_rounds,
                          input logic exp_cs, input logic exp_cf,
                          input int inj_round, input logic done_start);
    perm_sel_i = ps;
    variant_i  = vr;
    mode_i     = md;
    start_i    = 1'b1;
    tick();
    start_i    = 1'b0;
    perm_sel_i = ~ps;
    variant_i  = ~vr;
    mode_i     = ~md;
    for (int i = 0; i < exp_rounds; i++) begin
      string t;
      t = $sformatf("%s.r%0d", tag, i);
      check_val({t, ".loop"}, {29'd0, loop_num_o},     exp_start + i);
      check_val({t, ".load"}, {31'd0, state_load_o},   (i == 0) ? 32'd1 : 32'd0);
      check_val({t, ".en"},   {31'd0, state_en_o},     32'd1);
      check_val({t, ".busy"}, {31'd0, busy_o},         32'd1);
      check_val({t, ".rdy"},  {31'd0, ready_o},        32'd0);
      check_val({t, ".csel"}, {31'd0, const_sel_o},    {31'd0, exp_cs});
      check_val({t, ".cf"},   {31'd0, compact_fast_o}, {31'd0, exp_cf});
      check_val({t, ".done"}, {31'd0, done_o},         32'd0);
      start_i = (i == inj_round);
      tick();
      start_i = 1'b0;
    end
    check_val({tag, ".d.done"}, {31'd0, done_o},         32'd1);
    check_val({tag, ".d.en"},   {31'd0, state_en_o},     32'd0);
    check_val({tag, ".d.busy"}, {31'd0, busy_o},         32'd1);
    check_val({tag, ".d.rdy"},  {31'd0, ready_o},        32'd0);
    check_val({tag, ".d.loop"}, {29'd0, loop_num_o},     32'd5);
    check_val({tag, ".d.csel"}, {31'd0, const_sel_o},    {31'd0, exp_cs});
    check_val({tag, ".d.cf"},   {31'd0, compact_fast_o}, {31'd0, exp_cf});
    start_i = done_start;
    tick();
    start_i = 1'b0;
    check_idle({tag, ".i"});
  endtask

  initial begin
    rst        = 1'b1;
    start_i    = 1'b0;
    perm_sel_i = 1'b0;
    variant_i  = 1'b0;
    mode_i     = 1'b0;
    tick();
    tick();
    check_idle("reset");
    rst = 1'b0;
    tick();
    check_idle("post_reset");

    // pa compact: loop 0..5, done 7 cycles after accept
    run_perm("pa", 1'b0, 1'b0, 1'b0, 0, 6, 1'b0, 1'b0, -1, 1'b0);
    // pb Ascon-128: loop 3..5, done at cycle 4
    run_perm("pb128", 1'b1, 1'b0, 1'b0, 3, 3, 1'b0, 1'b0, -1, 1'b0);
    // pb Ascon-128a fast: loop 2..5, const_sel and compact_fast high
    run_perm("pb128a", 1'b1, 1'b1, 1'b1, 2, 4, 1'b1, 1'b1, -1, 1'b0);
    // pa with variant=1, start pulses while busy and on the done cycle ignored
    run_perm("pa_v1", 1'b0, 1'b1, 1'b0, 0, 6, 1'b0, 1'b0, 2, 1'b1);
    for (int k = 0; k < 8; k++) begin
      tick();
      check_idle($sformatf("pa_v1.noreq%0d", k));
    end

    // reset on the 3rd ROUND cycle of pa
    perm_sel_i = 1'b0;
    variant_i  = 1'b0;
    mode_i     = 1'b1;
    start_i    = 1'b1;
    tick();
    start_i = 1'b0;
    check_val("rst_mid.r0.loop", {29'd0, loop_num_o}, 32'd0);
    tick();
    check_val("rst_mid.r1.loop", {29'd0, loop_num_o}, 32'd1);
    tick();
    check_val("rst_mid.r2.loop", {29'd0, loop_num_o}, 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("rst_mid.after");
    for (int k = 0; k < 8; k++) begin
      tick();
      check_idle($sformatf("rst_mid.quiet%0d", k));
    end
    run_perm("rst_pb128", 1'b1, 1'b0, 1'b0, 3, 3, 1'b0, 1'b0, -1, 1'b0);

    // back-to-back: second start on first IDLE cycle after done
    run_perm("b2b_a", 1'b1, 1'b0, 1'b0, 3, 3, 1'b0, 1'b0, -1, 1'b0);
    run_perm("b2b_b", 1'b1, 1'b0, 1'b1, 3, 3, 1'b0, 1'b1, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
